alu_result_stage: RTL

//  Registered output stage directly downstream of the logical and shift units.
//  Per opcode, selects the logical-unit or shift-unit result. Computes status flags
//  and buffers results in a 2-entry skid FIFO with valid/ready handshakes on both sides.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_skid_fifo.sv | 59 +++++
 rtl/alu_result_stage.sv | 93 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and the per-entry flag record for the ALU result path.
// Optional feature: PARITY_FLAG_EN adds a stored parity bit to every entry.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef struct packed {
    logic zero;
    logic oob;
    logic bad_op;
`ifdef PARITY_FLAG_EN
    logic parity;
`endif
  } entry_flags_t;

  function automatic logic is_shift(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_skid_fifo.sv
// Two-entry FIFO with registered head; ready depends only on occupancy, never on out_ready.
module alu_skid_fifo #(
  parameter int P = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [P-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_data
);

  logic [1:0]   occ_reg, occ_next;
  logic [P-1:0] head_reg, head_next;
  logic [P-1:0] tail_reg, tail_next;
  logic         push, pop;

  assign in_ready  = !rst && (occ_reg != 2'd2);
  assign out_valid = (occ_reg != 2'd0);
  assign out_data  = head_reg;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_next  = occ_reg;
    head_next = head_reg;
    tail_next = tail_reg;
    case ({push, pop})
      2'b10: begin
        occ_next = occ_reg + 2'd1;
        if (occ_reg == 2'd0) head_next = in_data;
        else                 tail_next = in_data;
      end
      2'b01: begin
        occ_next  = occ_reg - 2'd1;
        head_next = tail_reg;
        tail_next = '0;
      end
      // Push and pop together only happen at occupancy 1: the new entry replaces the head.
      2'b11:   head_next = in_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_reg  <= 2'd0;
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      occ_reg  <= occ_next;
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Result select, flag generation and completed-result counter in front of a 2-entry FIFO.
// Optional feature: PARITY_FLAG_EN adds the parity_flag output.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] b_operand,
  input  logic [WIDTH-1:0] y_logic,
  input  logic [WIDTH-1:0] y_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             shift_oob,
  output logic             bad_op,
`ifdef PARITY_FLAG_EN
  output logic             parity_flag,
`endif
  output logic [CNT_W-1:0] done_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    entry_flags_t     flags;
  } entry_t;

  localparam logic [WIDTH-1:0] WIDTH_VAL = WIDTH'(WIDTH);

  entry_t           in_entry, head_entry;
  logic [WIDTH-1:0] sel_result;
  logic             sel_bad;
  logic [CNT_W-1:0] count_reg;

  always_comb begin
    sel_result = '0;
    sel_bad    = 1'b0;
    case (operation)
      OP_AND, OP_OR, OP_XOR, OP_NOT: sel_result = y_logic;
      OP_SHL, OP_SHR:                sel_result = y_shift;
      default:                       sel_bad    = 1'b1;
    endcase
  end

  always_comb begin
    in_entry              = '0;
    in_entry.result       = sel_result;
    in_entry.flags.zero   = (sel_result == '0);
    in_entry.flags.oob    = is_shift(operation) && (b_operand >= WIDTH_VAL);
    in_entry.flags.bad_op = sel_bad;
`ifdef PARITY_FLAG_EN
    in_entry.flags.parity = ^sel_result;
`endif
  end

  alu_skid_fifo #(
    .P($bits(entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_entry)
  );

  assign result    = head_entry.result;
  assign zero_flag = head_entry.flags.zero;
  assign shift_oob = head_entry.flags.oob;
  assign bad_op    = head_entry.flags.bad_op;
`ifdef PARITY_FLAG_EN
  assign parity_flag = head_entry.flags.parity;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (out_valid && out_ready && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign done_count = count_reg;

endmodule
